// File: rtl/sramc_requant_stage.sv
// sramc_requant_stage: per-lane requantizing write pipeline in front of the SRAMC port.
// Reads bypass combinationally; delayed writes wait in a small FIFO whenever a read takes the port.
module sramc_requant_stage #(
    parameter int SRAMC_W = 128,
    parameter int SRAMC_N = 8,
    parameter int ADRC_W  = 10,
    parameter int OUT_W   = 8,
    parameter int WFIFO_D = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [ADRC_W-1:0]   i_addr,
    input  logic                i_wren,
    input  logic                i_rden,
    input  logic [SRAMC_N-1:0]  i_wmask,
    input  logic [SRAMC_W-1:0]  i_wdata,
    input  logic                i_cfg_en,
    input  logic [15:0]         i_cfg_scale,
    input  logic [4:0]          i_cfg_shift,
    input  logic [OUT_W-1:0]    i_cfg_zp,
    input  logic                i_cfg_load,
    input  logic                i_clr_stat,
    output logic [ADRC_W-1:0]   o_addr,
    output logic                o_wren,
    output logic                o_rden,
    output logic [SRAMC_N-1:0]  o_wmask,
    output logic [SRAMC_W-1:0]  o_wdata,
    output logic                o_busy,
    output logic [15:0]         o_sat_cnt,
    output logic                o_hazard,
    output logic                o_overflow
);
    localparam int LW  = SRAMC_W / SRAMC_N;
    localparam int PW  = LW + 17;
    localparam int FAW = (WFIFO_D > 1) ? $clog2(WFIFO_D) : 1;
    localparam int EW  = ADRC_W + SRAMC_N + SRAMC_W;
    localparam logic signed [PW-1:0] SAT_HI = PW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_LO = ~SAT_HI;

    logic                     cfg_en, pend_en, pend, cap;
    logic signed [15:0]       cfg_scale, pend_scale;
    logic [4:0]               cfg_shift, pend_shift;
    logic signed [OUT_W-1:0]  cfg_zp, pend_zp;

    logic                     v1, v2, v3;
    logic [ADRC_W-1:0]        a1, a2, a3;
    logic [SRAMC_N-1:0]       m1, m2, m3, sat3, sat_n, sat_m;
    logic [SRAMC_W-1:0]       d1, d2, d3, d3_n;
    logic signed [PW-1:0]     p1 [SRAMC_N];
    logic signed [PW-1:0]     p2 [SRAMC_N];
    logic signed [PW-1:0]     prod [SRAMC_N];
    logic signed [PW-1:0]     rnd [SRAMC_N];
    logic signed [PW-1:0]     zsum [SRAMC_N];
    logic signed [PW-1:0]     bias;

    logic [EW-1:0]            mem [WFIFO_D];
    logic [EW-1:0]            head, sel;
    logic [FAW-1:0]           wp, rp, off;
    logic [FAW:0]             cnt;
    logic                     empty, full, push, pop, drop, wr, hit;
    logic [16:0]              sat_sum;

    // The one-cycle-early pipeline keeps config stable: captures only happen with nothing in flight.
    assign cap = !o_busy && !i_wren;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cfg_en     <= 1'b0;
            cfg_scale  <= 16'sd1;
            cfg_shift  <= '0;
            cfg_zp     <= '0;
            pend       <= 1'b0;
            pend_en    <= 1'b0;
            pend_scale <= '0;
            pend_shift <= '0;
            pend_zp    <= '0;
        end else begin
            pend <= (pend || i_cfg_load) && !cap;
            if (i_cfg_load) begin
                pend_en    <= i_cfg_en;
                pend_scale <= i_cfg_scale;
                pend_shift <= i_cfg_shift;
                pend_zp    <= i_cfg_zp;
            end
            if (cap && i_cfg_load) begin
                cfg_en    <= i_cfg_en;
                cfg_scale <= i_cfg_scale;
                cfg_shift <= i_cfg_shift;
                cfg_zp    <= i_cfg_zp;
            end else if (cap && pend) begin
                cfg_en    <= pend_en;
                cfg_scale <= pend_scale;
                cfg_shift <= pend_shift;
                cfg_zp    <= pend_zp;
            end
        end
    end

    always_comb begin
        bias  = (cfg_shift != 5'd0) ? (PW'(1) << (cfg_shift - 5'd1)) : '0;
        d3_n  = '0;
        sat_n = '0;
        for (int i = 0; i < SRAMC_N; i++) begin
            prod[i] = PW'($signed(i_wdata[i*LW +: LW])) * PW'(cfg_scale);
            rnd[i]  = (p1[i] + bias) >>> cfg_shift;
            zsum[i] = p2[i] + PW'(cfg_zp);
            sat_n[i] = cfg_en && (zsum[i] > SAT_HI || zsum[i] < SAT_LO);
            d3_n[i*LW +: LW] = !cfg_en ? d2[i*LW +: LW] :
                               (zsum[i] > SAT_HI) ? SAT_HI[LW-1:0] :
                               (zsum[i] < SAT_LO) ? SAT_LO[LW-1:0] : zsum[i][LW-1:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            {v1, v2, v3} <= '0;
            {a1, a2, a3} <= '0;
            {m1, m2, m3} <= '0;
            {d1, d2, d3} <= '0;
            sat3 <= '0;
            for (int i = 0; i < SRAMC_N; i++) begin
                p1[i] <= '0;
                p2[i] <= '0;
            end
        end else begin
            v1   <= i_wren;
            a1   <= i_addr;
            m1   <= i_wmask;
            d1   <= i_wdata;
            v2   <= v1;
            a2   <= a1;
            m2   <= m1;
            d2   <= d1;
            v3   <= v2;
            a3   <= a2;
            m3   <= m2;
            d3   <= d3_n;
            sat3 <= sat_n;
            for (int i = 0; i < SRAMC_N; i++) begin
                p1[i] <= prod[i];
                p2[i] <= rnd[i];
            end
        end
    end

    assign empty = cnt == '0;
    assign full  = cnt == (FAW+1)'(WFIFO_D);
    assign pop   = !i_rden && !empty;
    assign push  = v3 && (i_rden || !empty);
    assign drop  = push && full && !pop;
    assign wr    = push && !drop;
    assign head  = mem[rp];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr) wp <= wp + FAW'(1);
            if (pop) rp <= rp + FAW'(1);
            cnt <= cnt + (FAW+1)'(wr) - (FAW+1)'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr) mem[wp] <= {a3, m3, d3};
    end

    assign sel     = empty ? {a3, m3, d3} : head;
    assign o_rden  = i_rden;
    assign o_wren  = !i_rden && (!empty || v3);
    assign o_addr  = i_rden ? i_addr : o_wren ? sel[EW-1 -: ADRC_W] : '0;
    assign o_wmask = o_wren ? sel[SRAMC_W +: SRAMC_N] : '0;
    assign o_wdata = o_wren ? sel[SRAMC_W-1:0] : '0;
    assign o_busy  = v1 || v2 || v3 || !empty;

    // A coincident i_wren shares i_addr with the read, so it always collides.
    always_comb begin
        hit = i_wren || (v1 && a1 == i_addr) || (v2 && a2 == i_addr) || (v3 && a3 == i_addr);
        off = '0;
        for (int k = 0; k < WFIFO_D; k++) begin
            off = FAW'(k) - rp;
            if ({1'b0, off} < cnt && mem[k][EW-1 -: ADRC_W] == i_addr) hit = 1'b1;
        end
    end

    assign sat_m   = v3 ? (sat3 & m3) : '0;
    assign sat_sum = {1'b0, o_sat_cnt} + 17'($countones(sat_m));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sat_cnt  <= '0;
            o_hazard   <= 1'b0;
            o_overflow <= 1'b0;
        end else if (i_clr_stat) begin
            o_sat_cnt  <= '0;
            o_hazard   <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_sat_cnt  <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
            o_hazard   <= o_hazard || (i_rden && hit);
            o_overflow <= o_overflow || drop;
        end
    end
endmodule

// File: tb/tb_sramc_requant_stage.sv
// tb_sramc_requant_stage: directed stimulus; expected writes queued with their issue cycle,
// a negedge monitor pops and compares every write presented on the SRAMC port.
module tb_sramc_requant_stage;
    logic         i_clk = 1'b0, i_rst = 1'b1;
    logic [9:0]   i_addr = '0;
    logic         i_wren = 1'b0, i_rden = 1'b0;
    logic [7:0]   i_wmask = '0;
    logic [127:0] i_wdata = '0;
    logic         i_cfg_en = 1'b0;
    logic [15:0]  i_cfg_scale = 16'd1;
    logic [4:0]   i_cfg_shift = '0;
    logic [7:0]   i_cfg_zp = '0;
    logic         i_cfg_load = 1'b0, i_clr_stat = 1'b0;
    logic [9:0]   o_addr;
    logic         o_wren, o_rden, o_busy, o_hazard, o_overflow;
    logic [7:0]   o_wmask;
    logic [127:0] o_wdata;
    logic [15:0]  o_sat_cnt;

    sramc_requant_stage dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_addr(i_addr), .i_wren(i_wren), .i_rden(i_rden),
        .i_wmask(i_wmask), .i_wdata(i_wdata), .i_cfg_en(i_cfg_en), .i_cfg_scale(i_cfg_scale),
        .i_cfg_shift(i_cfg_shift), .i_cfg_zp(i_cfg_zp), .i_cfg_load(i_cfg_load),
        .i_clr_stat(i_clr_stat), .o_addr(o_addr), .o_wren(o_wren), .o_rden(o_rden),
        .o_wmask(o_wmask), .o_wdata(o_wdata), .o_busy(o_busy), .o_sat_cnt(o_sat_cnt),
        .o_hazard(o_hazard), .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    int checks = 0;
    int fails = 0;
    always @(posedge i_clk) cyc++;

    typedef struct {
        logic [9:0]   a;
        logic [7:0]   m;
        logic [127:0] d;
        int           c;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [127:0] rep(input logic [15:0] v);
        return {8{v}};
    endfunction

    task automatic expect_wr(input logic [9:0] a, input logic [7:0] m, input logic [127:0] d, input int c);
        exp_t e;
        e.a = a;
        e.m = m;
        e.d = d;
        e.c = c;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic we, input logic re, input logic [9:0] a, input logic [7:0] m,
                        input logic [127:0] d, input logic ld, input logic clr);
        @(posedge i_clk);
        #1;
        i_wren = we;
        i_rden = re;
        i_addr = a;
        i_wmask = m;
        i_wdata = d;
        i_cfg_load = ld;
        i_clr_stat = clr;
        @(negedge i_clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((o_busy || exp_q.size() != 0) && n < 60) begin
            idle();
            n++;
        end
        chk("drain_timeout", {127'd0, o_busy || exp_q.size() != 0}, 128'd0);
    endtask

    always @(negedge i_clk) begin : monitor
        exp_t e;
        if (!i_rst && o_wren) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL wr_unexpected: actual write addr %0h data %0h required none (cycle %0d)", o_addr, o_wdata, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", o_addr, e.a);
                chk("wr_mask", o_wmask, e.m);
                chk("wr_data", o_wdata, e.d);
                chk("wr_cycle", cyc, e.c);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0;
        repeat (2) @(negedge i_clk);
        chk("rst_wren", o_wren, 0);
        chk("rst_rden", o_rden, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_wdata", o_wdata, 0);
        chk("rst_sat", o_sat_cnt, 0);
        chk("rst_flags", {o_hazard, o_overflow}, 0);
        @(posedge i_clk);
        #1 i_rst = 1'b0;

        // reset config: en = 0, data passes unmodified
        step(1'b1, 1'b0, 10'h3FF, 8'hA5, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0, 1'b0);
        expect_wr(10'h3FF, 8'hA5, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, cyc + 3);
        idle();
        chk("busy_inflight", o_busy, 1);
        wait_idle();
        chk("sat_pass", o_sat_cnt, 0);

        // scale 3, shift 2, zp -5
        i_cfg_en = 1'b1; i_cfg_scale = 16'd3; i_cfg_shift = 5'd2; i_cfg_zp = 8'hFB;
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 10'h001, 8'hFF, rep(16'd10), 1'b0, 1'b0);
        expect_wr(10'h001, 8'hFF, rep(16'h0003), cyc + 3);
        step(1'b1, 1'b0, 10'h002, 8'hFF,
             {16'h0007, 16'h0001, 16'hFC18, 16'h03E8, 16'h0064, 16'h0000, 16'hFFF6, 16'h000A}, 1'b0, 1'b0);
        expect_wr(10'h002, 8'hFF,
                  {16'h0000, 16'hFFFC, 16'hFF80, 16'h007F, 16'h0046, 16'hFFFB, 16'hFFF4, 16'h0003}, cyc + 3);
        wait_idle();
        chk("sat_mixed", o_sat_cnt, 2);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
        idle();
        chk("sat_clr", o_sat_cnt, 0);

        // saturation: scale 16 on 0x7FFF
        i_cfg_scale = 16'd16; i_cfg_shift = 5'd0; i_cfg_zp = 8'h00;
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 10'h050, 8'hFF, rep(16'h7FFF), 1'b0, 1'b0);
        expect_wr(10'h050, 8'hFF, rep(16'h007F), cyc + 3);
        wait_idle();
        chk("sat_ff", o_sat_cnt, 8);
        step(1'b1, 1'b0, 10'h051, 8'h0F, rep(16'h7FFF), 1'b0, 1'b0);
        expect_wr(10'h051, 8'h0F, rep(16'h007F), cyc + 3);
        wait_idle();
        chk("sat_0f", o_sat_cnt, 12);

        // writes on cycles 0-3, reads on 3-6: FIFO drains on 7-10
        t0 = cyc + 1;
        for (int i = 0; i < 7; i++) begin
            logic [9:0] a;
            a = (i >= 3) ? 10'(10'h100 + i) : 10'(10'h020 + i);
            step(i < 4, i >= 3, a, 8'hFF, rep(16'(i + 1)), 1'b0, 1'b0);
            if (i < 4) expect_wr(a, 8'hFF, rep(16'(16 * (i + 1))), t0 + 7 + i);
            if (i >= 3) begin
                chk("rd_en", o_rden, 1);
                chk("rd_addr", o_addr, a);
                chk("rd_no_wr", o_wren, 0);
            end
        end
        wait_idle();
        chk("ovf_none", o_overflow, 0);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);

        // six writes then continuous reads: writes 5 and 6 dropped
        t0 = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            step(i < 6, i >= 3, 10'(10'h200 + i), 8'hFF, rep(16'(i + 1)), 1'b0, 1'b0);
            if (i < 4) expect_wr(10'(10'h200 + i), 8'hFF, rep(16'(16 * (i + 1))), t0 + 10 + i);
            if (i >= 3) chk("rd_busy_port", o_wren, 0);
        end
        wait_idle();
        chk("ovf_set", o_overflow, 1);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
        idle();
        chk("ovf_clr", o_overflow, 0);
        chk("haz_clr0", o_hazard, 0);

        // hazard: different address, same address, clear, clear beating a set
        step(1'b1, 1'b0, 10'h040, 8'hFF, rep(16'd1), 1'b0, 1'b0);
        expect_wr(10'h040, 8'hFF, rep(16'h0010), cyc + 3);
        idle();
        step(1'b0, 1'b1, 10'h041, '0, '0, 1'b0, 1'b0);
        idle();
        chk("haz_miss", o_hazard, 0);
        step(1'b1, 1'b0, 10'h012, 8'hFF, rep(16'd1), 1'b0, 1'b0);
        expect_wr(10'h012, 8'hFF, rep(16'h0010), cyc + 3);
        idle();
        step(1'b0, 1'b1, 10'h012, '0, '0, 1'b0, 1'b0);
        chk("haz_rd_issued", o_rden, 1);
        idle();
        chk("haz_hit", o_hazard, 1);
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
        idle();
        chk("haz_clr", o_hazard, 0);
        step(1'b1, 1'b0, 10'h012, 8'hFF, rep(16'd1), 1'b0, 1'b0);
        expect_wr(10'h012, 8'hFF, rep(16'h0010), cyc + 3);
        idle();
        step(1'b0, 1'b1, 10'h012, '0, '0, 1'b0, 1'b1);
        idle();
        chk("haz_clr_wins", o_hazard, 0);
        wait_idle();

        // config load while writes are in flight stays pending
        step(1'b1, 1'b0, 10'h060, 8'hFF, rep(16'd4), 1'b0, 1'b0);
        expect_wr(10'h060, 8'hFF, rep(16'h0040), cyc + 3);
        i_cfg_shift = 5'd4;
        step(1'b1, 1'b0, 10'h061, 8'hFF, rep(16'd4), 1'b1, 1'b0);
        expect_wr(10'h061, 8'hFF, rep(16'h0040), cyc + 3);
        wait_idle();
        idle();
        step(1'b1, 1'b0, 10'h062, 8'hFF, rep(16'd4), 1'b0, 1'b0);
        expect_wr(10'h062, 8'hFF, rep(16'h0004), cyc + 3);
        step(1'b1, 1'b0, 10'h063, 8'h33, rep(16'hFFF6), 1'b0, 1'b0);
        expect_wr(10'h063, 8'h33, rep(16'hFFF6), cyc + 3);
        wait_idle();

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
